rv32_execute_unit: RTL and testbench

Registered execute stage for the RV32I core. It combines a structural 32-bit adder, the integer ALU and the branch comparator. Each cycle it forms the ALU result, the branch decision and the next PC from decoded control and operand values. Outputs are registered, and the block sits between decode/register-file read and the LSU/writeback/PC register.

---
 rtl/rv32_execute_unit.sv | 123 ++++++++++++
 tb/tb_rv32_execute_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rv32_execute_unit.sv
// rv32_execute_unit: registered RV32I execute stage (adder chains, ALU, branch compare, next PC).
// Optional macro EXEC_BR_UNSIGNED_FUNCT3_EN: BLTU/BGEU compare unsigned regardless of i_br_un.
module rv32_adder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout,
    output logic        o_ovf
);
    logic [32:0] c;
    assign c[0] = i_cin;
    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign o_sum[i] = i_a[i] ^ i_b[i] ^ c[i];
        assign c[i+1]   = (i_a[i] & i_b[i]) | (c[i] & (i_a[i] ^ i_b[i]));
    end
    assign o_cout = c[32];
    assign o_ovf  = c[32] ^ c[31];
endmodule

module rv32_execute_unit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_imm,
    input  logic [3:0]  i_alu_op,
    input  logic        i_opa_sel,
    input  logic [1:0]  i_opb_sel,
    input  logic        i_br_un,
    input  logic [2:0]  i_funct3,
    input  logic        i_is_branch,
    input  logic        i_is_jal,
    input  logic        i_is_jalr,
    output logic        o_valid,
    output logic [31:0] o_alu_y,
    output logic        o_zero,
    output logic        o_br_equal,
    output logic        o_br_less,
    output logic        o_take,
    output logic [31:0] o_pc_next
);
    logic [31:0] opa, opb, alu_sum, pc_imm, rs1_imm, pc_4;
    logic        sub, alu_co, alu_ov, pi_co, pi_ov, ri_co, ri_ov, p4_co, p4_ov, br_un_eff, cond;
    logic        valid_d, zero_d, br_equal_d, br_less_d, take_d;
    logic [31:0] alu_y_d, pc_next_d;
    logic        valid_q, zero_q, br_equal_q, br_less_q, take_q;
    logic [31:0] alu_y_q, pc_next_q;
    logic        unused_bits;

    assign opa = i_opa_sel ? i_pc : i_rs1;
    assign opb = (i_opb_sel == 2'b00) ? i_rs2 : (i_opb_sel == 2'b01) ? i_imm : 32'd4;
    assign sub = (i_alu_op == 4'd1) || (i_alu_op == 4'd3) || (i_alu_op == 4'd4);

    rv32_adder u_alu_add (.i_a(opa),   .i_b(sub ? ~opb : opb), .i_cin(sub),  .o_sum(alu_sum), .o_cout(alu_co), .o_ovf(alu_ov));
    rv32_adder u_pc_imm  (.i_a(i_pc),  .i_b(i_imm),            .i_cin(1'b0), .o_sum(pc_imm),  .o_cout(pi_co),  .o_ovf(pi_ov));
    rv32_adder u_rs1_imm (.i_a(i_rs1), .i_b(i_imm),            .i_cin(1'b0), .o_sum(rs1_imm), .o_cout(ri_co),  .o_ovf(ri_ov));
    rv32_adder u_pc_4    (.i_a(i_pc),  .i_b(32'd4),            .i_cin(1'b0), .o_sum(pc_4),    .o_cout(p4_co),  .o_ovf(p4_ov));

    assign unused_bits = ^{pi_co, pi_ov, ri_co, ri_ov, p4_co, p4_ov, rs1_imm[0]};

`ifdef EXEC_BR_UNSIGNED_FUNCT3_EN
    assign br_un_eff = i_br_un | (i_is_branch & (i_funct3[2:1] == 2'b11));
`else
    assign br_un_eff = i_br_un;
`endif

    always_comb begin
        alu_y_d = 32'd0;
        case (i_alu_op)
            4'd0, 4'd1: alu_y_d = alu_sum;
            4'd2:       alu_y_d = opa << opb[4:0];
            4'd3:       alu_y_d = {31'd0, alu_sum[31] ^ alu_ov};
            4'd4:       alu_y_d = {31'd0, ~alu_co};
            4'd5:       alu_y_d = opa ^ opb;
            4'd6:       alu_y_d = opa >> opb[4:0];
            4'd7:       alu_y_d = $unsigned($signed(opa) >>> opb[4:0]);
            4'd8:       alu_y_d = opa | opb;
            4'd9:       alu_y_d = opa & opb;
            4'd10:      alu_y_d = opb;
            default:    alu_y_d = 32'd0;
        endcase
        valid_d    = i_valid;
        zero_d     = (alu_y_d == 32'd0);
        br_equal_d = (i_rs1 == i_rs2);
        br_less_d  = br_un_eff ? (i_rs1 < i_rs2) : ($signed(i_rs1) < $signed(i_rs2));
        // funct3[0] inverts the base condition; 01x never branches
        cond       = (i_funct3[2:1] == 2'b00) ? (br_equal_d ^ i_funct3[0]) :
                     i_funct3[2] ? (br_less_d ^ i_funct3[0]) : 1'b0;
        take_d     = i_is_jalr | i_is_jal | (i_is_branch & cond);
        pc_next_d  = i_is_jalr ? {rs1_imm[31:1], 1'b0} : take_d ? pc_imm : pc_4;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q    <= 1'b0;
            alu_y_q    <= 32'd0;
            zero_q     <= 1'b0;
            br_equal_q <= 1'b0;
            br_less_q  <= 1'b0;
            take_q     <= 1'b0;
            pc_next_q  <= 32'd0;
        end else begin
            valid_q    <= valid_d;
            alu_y_q    <= alu_y_d;
            zero_q     <= zero_d;
            br_equal_q <= br_equal_d;
            br_less_q  <= br_less_d;
            take_q     <= take_d;
            pc_next_q  <= pc_next_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_alu_y    = alu_y_q;
    assign o_zero     = zero_q;
    assign o_br_equal = br_equal_q;
    assign o_br_less  = br_less_q;
    assign o_take     = take_q;
    assign o_pc_next  = pc_next_q;
endmodule

// File: tb/tb_rv32_execute_unit.sv
// tb_rv32_execute_unit: randomized + directed scoreboard bench against a behavioural model.
module tb_rv32_execute_unit;
    logic        i_clk = 0, i_rst = 1, i_valid = 0;
    logic [31:0] i_pc = 0, i_rs1 = 0, i_rs2 = 0, i_imm = 0;
    logic [3:0]  i_alu_op = 0;
    logic        i_opa_sel = 0, i_br_un = 0, i_is_branch = 0, i_is_jal = 0, i_is_jalr = 0;
    logic [1:0]  i_opb_sel = 0;
    logic [2:0]  i_funct3 = 0;
    logic        o_valid, o_zero, o_br_equal, o_br_less, o_take;
    logic [31:0] o_alu_y, o_pc_next;

    typedef struct {
        logic [31:0] y;
        logic        z, eq, lt, tk;
        logic [31:0] pn;
        string       nm;
    } exp_t;

    exp_t q[$];
    int checks = 0, failures = 0;

    rv32_execute_unit dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_pc(i_pc), .i_rs1(i_rs1),
        .i_rs2(i_rs2), .i_imm(i_imm), .i_alu_op(i_alu_op), .i_opa_sel(i_opa_sel),
        .i_opb_sel(i_opb_sel), .i_br_un(i_br_un), .i_funct3(i_funct3),
        .i_is_branch(i_is_branch), .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr),
        .o_valid(o_valid), .o_alu_y(o_alu_y), .o_zero(o_zero), .o_br_equal(o_br_equal),
        .o_br_less(o_br_less), .o_take(o_take), .o_pc_next(o_pc_next)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [31:0] pc, rs1, rs2, imm, input logic [3:0] op,
                                   input logic opa_s, input logic [1:0] opb_s, input logic un,
                                   input logic [2:0] f3, input logic br, jal, jalr);
        exp_t e;
        logic [31:0] a, b;
        logic uns, c;
        a = opa_s ? pc : rs1;
        b = (opb_s == 0) ? rs2 : (opb_s == 1) ? imm : 32'd4;
        case (op)
            0: e.y = a + b;
            1: e.y = a - b;
            2: e.y = a << b[4:0];
            3: e.y = {31'd0, $signed(a) < $signed(b)};
            4: e.y = {31'd0, a < b};
            5: e.y = a ^ b;
            6: e.y = a >> b[4:0];
            7: e.y = $unsigned($signed(a) >>> b[4:0]);
            8: e.y = a | b;
            9: e.y = a & b;
            10: e.y = b;
            default: e.y = 0;
        endcase
        e.z = (e.y == 0);
        uns = un;
`ifdef EXEC_BR_UNSIGNED_FUNCT3_EN
        if (br && (f3 == 3'b110 || f3 == 3'b111)) uns = 1;
`endif
        e.eq = (rs1 == rs2);
        e.lt = uns ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
        case (f3)
            0: c = e.eq;
            1: c = !e.eq;
            4, 6: c = e.lt;
            5, 7: c = !e.lt;
            default: c = 0;
        endcase
        e.tk = jalr || jal || (br && c);
        e.pn = jalr ? ((rs1 + imm) & ~32'd1) : (jal || (br && c)) ? pc + imm : pc + 4;
        return e;
    endfunction

    task automatic issue(input string nm, input logic [31:0] pc, rs1, rs2, imm, input logic [3:0] op,
                         input logic opa_s, input logic [1:0] opb_s, input logic un,
                         input logic [2:0] f3, input logic br, jal, jalr);
        exp_t e;
        @(negedge i_clk);
        {i_pc, i_rs1, i_rs2, i_imm, i_alu_op} = {pc, rs1, rs2, imm, op};
        {i_opa_sel, i_opb_sel, i_br_un, i_funct3} = {opa_s, opb_s, un, f3};
        {i_is_branch, i_is_jal, i_is_jalr, i_valid} = {br, jal, jalr, 1'b1};
        e = model(pc, rs1, rs2, imm, op, opa_s, opb_s, un, f3, br, jal, jalr);
        e.nm = nm;
        q.push_back(e);
    endtask

    task automatic randomize_inputs();
        {i_pc, i_rs1, i_rs2, i_imm} = {$urandom, $urandom, $urandom, $urandom};
        i_alu_op = 4'($urandom);
        {i_opa_sel, i_opb_sel, i_br_un, i_funct3} = 7'($urandom);
        {i_is_branch, i_is_jal, i_is_jalr, i_valid} = 4'($urandom) | 4'b0001;
    endtask

    always @(posedge i_clk) begin
        #1;
        if (!i_rst && o_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 required=0");
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.nm, ".alu_y"}, o_alu_y, e.y);
                check({e.nm, ".flags"}, {27'd0, o_zero, o_br_equal, o_br_less, o_take},
                      {27'd0, e.z, e.eq, e.lt, e.tk});
                check({e.nm, ".pc_next"}, o_pc_next, e.pn);
            end
        end
    end

    initial begin
        repeat (3) begin
            @(negedge i_clk);
            randomize_inputs();
        end
        @(negedge i_clk);
        check("reset.valid", {31'd0, o_valid}, 0);
        check("reset.alu_y", o_alu_y, 0);
        check("reset.flags", {28'd0, o_zero, o_br_equal, o_br_less, o_take}, 0);
        check("reset.pc_next", o_pc_next, 0);
        i_rst = 0;
        i_valid = 0;
        issue("add5_7",   0, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue("sub0_1",   0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        issue("slt",      0, 32'hFFFFFFFF, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        issue("sltu",     0, 32'hFFFFFFFF, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0);
        issue("sra",      0, 32'h80000000, 4, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        issue("sll35",    0, 1, 35, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        issue("add_ovf",  0, 32'h7FFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue("op12",     0, 9, 3, 0, 12, 0, 0, 0, 0, 0, 0, 0);
        issue("lui",      0, 9, 3, 32'hABCDE000, 10, 0, 1, 0, 0, 0, 0, 0);
        issue("beq",      32'h100, 3, 3, -32'sd8, 0, 0, 0, 0, 3'b000, 1, 0, 0);
        issue("bne",      32'h100, 3, 3, -32'sd8, 0, 0, 0, 0, 3'b001, 1, 0, 0);
        issue("f3_010",   32'h100, 3, 3, -32'sd8, 0, 0, 0, 0, 3'b010, 1, 0, 0);
        issue("bltu_un0", 32'h100, 32'hFFFFFFFF, 1, -32'sd8, 0, 0, 0, 0, 3'b110, 1, 0, 0);
        issue("bltu_un1", 32'h100, 32'hFFFFFFFF, 1, -32'sd8, 0, 0, 0, 1, 3'b110, 1, 0, 0);
        issue("blt",      32'h100, 32'hFFFFFFFF, 1, -32'sd8, 0, 0, 0, 0, 3'b100, 1, 0, 0);
        issue("jalr",     32'h300, 32'h1001, 0, 4, 0, 1, 2, 0, 0, 0, 0, 1);
        issue("jal_jalr", 32'h300, 32'h1001, 0, 4, 0, 1, 2, 0, 0, 0, 1, 1);
        issue("jal",      32'h200, 0, 0, 32'h10, 0, 1, 2, 0, 0, 0, 1, 0);
        issue("br_jal",   32'h200, 5, 6, 32'h10, 0, 0, 0, 0, 3'b000, 1, 1, 0);
        issue("opmux",    32'h40, 7, 9, 32'h10, 0, 1, 2, 0, 0, 0, 0, 0);
        @(negedge i_clk);
        i_valid = 0;
        @(negedge i_clk);
        #2;
        check("y_before_mid_reset", o_alu_y, 32'h44);
        i_rst = 1;
        #1;
        check("mid_reset.valid_alu", {31'd0, o_valid} | o_alu_y, 0);
        check("mid_reset.pc_next", o_pc_next, 0);
        @(negedge i_clk);
        i_rst = 0;
        for (int n = 0; n < 400; n++) begin
            exp_t e;
            @(negedge i_clk);
            randomize_inputs();
            i_valid = ($urandom_range(0, 7) != 0);
            if (i_valid) begin
                e = model(i_pc, i_rs1, i_rs2, i_imm, i_alu_op, i_opa_sel, i_opb_sel, i_br_un,
                          i_funct3, i_is_branch, i_is_jal, i_is_jalr);
                e.nm = $sformatf("rand%0d", n);
                q.push_back(e);
            end
        end
        @(negedge i_clk);
        i_valid = 0;
        repeat (3) @(negedge i_clk);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
